// File: rtl/mat_pkg.sv
// Shared constants and FSM state encoding for the matrix frame loader.
//   DATA_W    : width of a/b and of each sample half
//   FRAME_LEN : samples per frame; terminator index is FRAME_LEN+1
//   IDX_W     : width of the downstream write index
package mat_pkg;

  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 512;
  localparam int IDX_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    DRAIN,
    TERM,
    DONE
  } state_t;

endpackage

// File: rtl/mat_frame_loader_if.sv
// Sample stream in / indexed write stream out of the frame loader.
//   s_valid/s_ready/s_real/s_imag/s_last : upstream complex sample stream
//   a/b/index                             : downstream indexed write
// slave  : loader view; master : producer/consumer view.
interface mat_frame_loader_if #(
  parameter int DATA_W = mat_pkg::DATA_W,
  parameter int IDX_W  = mat_pkg::IDX_W
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_real;
  logic [DATA_W-1:0] s_imag;
  logic              s_last;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [IDX_W-1:0]  index;

  modport master (
    output s_valid, s_real, s_imag, s_last,
    input  s_ready, a, b, index
  );

  modport slave (
    input  s_valid, s_real, s_imag, s_last,
    output s_ready, a, b, index
  );

endinterface

// File: rtl/mat_sync_fifo.sv
// Synchronous FIFO with AW+1 bit pointers; full/empty from the MSB compare.
//   clk, rst (async, active-low)
//   push_i, wr_data_i : write side (push while full is accepted if a pop
//                       happens in the same cycle)
//   pop_i, rd_data_o  : read side, rd_data_o is the current head (show-ahead)
//   full_o, empty_o   : status
module mat_sync_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mat_frame_loader.sv
// Frame loader: buffers a valid/ready complex sample stream and replays it as
// the indexed a/b/index write sequence 1..FRAME_LEN followed by the
// FRAME_LEN+1 terminator. Short frames are zero-padded (err_short), long
// frames are truncated and the excess discarded (err_long).
//   clk, rst (async, active-low)
//   start      : one-cycle pulse, arms one frame (ignored while busy)
//   swap       : only with MAT_FRAME_LOADER_SWAP_EN; sampled on start,
//                a<-imag, b<-real for the frame
//   busy       : start acceptance until DONE exits
//   frame_done : one-cycle pulse in DONE
//   err_short/err_long : sticky until the next start
//   io         : sample stream in, indexed write out
module mat_frame_loader #(
  parameter int DATA_W     = mat_pkg::DATA_W,
  parameter int FRAME_LEN  = mat_pkg::FRAME_LEN,
  parameter int FIFO_DEPTH = 8,
  parameter int IDX_W      = mat_pkg::IDX_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef MAT_FRAME_LOADER_SWAP_EN
  input  logic swap,
`endif
  output logic busy,
  output logic frame_done,
  output logic err_short,
  output logic err_long,
  mat_frame_loader_if.slave io
);

  import mat_pkg::*;

  localparam int               EW       = 2*DATA_W + 1;
  localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0] TERM_IDX = IDX_W'(FRAME_LEN + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_s_q, err_s_d, err_l_q, err_l_d;
  logic              last_seen_q, last_seen_d;
  logic [1:0]        term_cnt_q, term_cnt_d;
  logic              swap_q, swap_d, swap_in;

  logic              s_ready, hs, push, pop, full, empty;
  logic [EW-1:0]     rd_data;
  logic [DATA_W-1:0] rd_re, rd_im;
  logic              rd_last;

`ifdef MAT_FRAME_LOADER_SWAP_EN
  assign swap_in = swap;
`else
  assign swap_in = 1'b0;
`endif

  mat_sync_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i ({io.s_real, io.s_imag, io.s_last}),
    .pop_i     (pop),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign rd_re   = rd_data[EW-1 -: DATA_W];
  assign rd_im   = rd_data[DATA_W:1];
  assign rd_last = rd_data[0];

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      err_s_q     <= 1'b0;
      err_l_q     <= 1'b0;
      last_seen_q <= 1'b0;
      term_cnt_q  <= '0;
      swap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      err_s_q     <= err_s_d;
      err_l_q     <= err_l_d;
      last_seen_q <= last_seen_d;
      term_cnt_q  <= term_cnt_d;
      swap_q      <= swap_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    err_s_d     = err_s_q;
    err_l_d     = err_l_q;
    last_seen_d = last_seen_q;
    term_cnt_d  = '0;
    swap_d      = swap_q;
    // Once the frame's s_last has been taken, stop accepting so the next
    // frame's samples never slip into this one.
    if (hs && io.s_last) last_seen_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) begin
          state_d     = LOAD;
          err_s_d     = 1'b0;
          err_l_d     = 1'b0;
          last_seen_d = 1'b0;
          swap_d      = swap_in;
        end
      end
      LOAD: begin
        if (!empty) begin
          idx_d = idx_q + IDX_W'(1);
          a_d   = swap_q ? rd_im : rd_re;
          b_d   = swap_q ? rd_re : rd_im;
          if (idx_d == LEN_IDX) begin
            if (rd_last) state_d = TERM;
            else begin
              err_l_d = 1'b1;
              state_d = DRAIN;
            end
          end else if (rd_last) begin
            err_s_d = 1'b1;
            state_d = PAD;
          end
        end
      end
      PAD: begin
        idx_d = idx_q + IDX_W'(1);
        a_d   = '0;
        b_d   = '0;
        if (idx_d == LEN_IDX) state_d = TERM;
      end
      DRAIN: begin
        if ((pop && rd_last) || (hs && io.s_last)) state_d = TERM;
      end
      TERM: begin
        // First TERM cycle still shows index FRAME_LEN; the terminator is
        // then held for two full cycles before DONE.
        if (term_cnt_q == 2'd2) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          term_cnt_d = term_cnt_q + 2'd1;
          idx_d      = TERM_IDX;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    s_ready = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      LOAD: begin
        s_ready = !full && !last_seen_q;
        pop     = !empty;
      end
      // Excess samples bypass the FIFO and are dropped; anything still
      // queued is popped and dropped as well.
      DRAIN: begin
        s_ready = !last_seen_q;
        pop     = !empty;
      end
      TERM:    pop = !empty;
      default: ;
    endcase
  end

  assign hs   = io.s_valid && s_ready;
  assign push = hs && (state_q == LOAD);

  assign io.s_ready = s_ready;
  assign io.a       = a_q;
  assign io.b       = b_q;
  assign io.index   = idx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign err_short  = err_s_q;
  assign err_long   = err_l_q;

endmodule

// File: tb/tb_mat_frame_loader.sv
module tb_mat_frame_loader;
  import mat_pkg::*;

  localparam int DW = DATA_W;
  localparam int IW = IDX_W;
  localparam int FL = FRAME_LEN;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [IW-1:0] idx;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, frame_done, err_short, err_long;
`ifdef MAT_FRAME_LOADER_SWAP_EN
  logic swap = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  out_t obs_q[$];
  int term_cycles = 0;
  int done_pulses = 0;

  mat_frame_loader_if #(.DATA_W(DW), .IDX_W(IW)) io ();

  mat_frame_loader #(.DATA_W(DW), .FRAME_LEN(FL), .FIFO_DEPTH(8), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef MAT_FRAME_LOADER_SWAP_EN
    .swap       (swap),
`endif
    .busy       (busy),
    .frame_done (frame_done),
    .err_short  (err_short),
    .err_long   (err_long),
    .io         (io.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_index"}, 128'(io.index), 128'(0));
    chk({tag, "_a"}, 128'(io.a), 128'(0));
    chk({tag, "_b"}, 128'(io.b), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_frame_done"}, 128'(frame_done), 128'(0));
    chk({tag, "_err_short"}, 128'(err_short), 128'(0));
    chk({tag, "_err_long"}, 128'(err_long), 128'(0));
    chk({tag, "_s_ready"}, 128'(io.s_ready), 128'(0));
  endtask

  // Output monitor: record each newly presented in-frame index.
  initial begin
    logic [IW-1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (io.index != prev && io.index >= IW'(1) && io.index <= IW'(FL))
        obs_q.push_back({io.a, io.b, io.index});
      if (io.index == IW'(FL + 1)) term_cycles++;
      if (frame_done) done_pulses++;
      prev = io.index;
    end
  end

  // One frame: nsamp samples, s_last on sample lastp, gap = % chance of an
  // idle cycle before each sample.
  task automatic run_frame(input string tag, input int nsamp, input int lastp, input int gap,
                           input bit kpat, input bit busy_start, input bit rel_rst);
    logic [DW-1:0] re[$];
    logic [DW-1:0] im[$];
    out_t exp_q[$];
    out_t e;
    bit sw;
    bit r;
    int waited;
    sw = 1'b0;
`ifdef MAT_FRAME_LOADER_SWAP_EN
    sw = 1'($urandom_range(1));
`endif
    for (int i = 1; i <= nsamp; i++) begin
      re.push_back(kpat ? DW'(i)  : DW'($urandom));
      im.push_back(kpat ? DW'(-i) : DW'($urandom));
    end
    // Reference: samples up to s_last (capped at FL), zeros after an early s_last.
    for (int k = 1; k <= FL; k++) begin
      e.idx = IW'(k);
      if (k > lastp) begin
        e.a = '0;
        e.b = '0;
      end else begin
        e.a = sw ? im[k-1] : re[k-1];
        e.b = sw ? re[k-1] : im[k-1];
      end
      exp_q.push_back(e);
    end

    @(posedge clk); #1;
    obs_q.delete();
    term_cycles = 0;
    done_pulses = 0;
    start = 1'b1;
`ifdef MAT_FRAME_LOADER_SWAP_EN
    swap = sw;
`endif
    if (rel_rst) rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int i = 0; i < nsamp; i++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        io.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      io.s_valid = 1'b1;
      io.s_real  = re[i];
      io.s_imag  = im[i];
      io.s_last  = (i + 1 == lastp);
      if (busy_start && i == 10) start = 1'b1;
      waited = 0;
      r = 1'b0;
      while (!r && waited <= 200) begin
        @(negedge clk); r = io.s_ready;
        @(posedge clk); #1;
        start = 1'b0;
        waited++;
      end
      if (!r) begin
        chk({tag, "_hs_timeout"}, 128'(r), 128'(1));
        break;
      end
    end
    io.s_valid = 1'b0;
    io.s_last  = 1'b0;

    for (int c = 0; c < 3000 && done_pulses == 0; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;

    chk({tag, "_n_out"}, 128'(obs_q.size()), 128'(FL));
    for (int k = 0; k < FL; k++)
      if (k < obs_q.size()) chk({tag, "_sample"}, 128'(obs_q[k]), 128'(exp_q[k]));
    chk({tag, "_err_short"}, 128'(err_short), 128'(lastp < FL));
    chk({tag, "_err_long"}, 128'(err_long), 128'(lastp > FL));
    chk({tag, "_term_cycles"}, 128'(term_cycles), 128'(2));
    chk({tag, "_done_pulses"}, 128'(done_pulses), 128'(1));
    chk({tag, "_busy_after"}, 128'(busy), 128'(0));
    chk({tag, "_index_after"}, 128'(io.index), 128'(0));
  endtask

  initial begin
    io.s_valid = 1'b0;
    io.s_real  = '0;
    io.s_imag  = '0;
    io.s_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_rst("reset");
    rst = 1'b1;

    // Samples offered in IDLE must not be accepted.
    io.s_valid = 1'b1;
    io.s_real  = DW'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_s_ready", 128'(io.s_ready), 128'(0));
    end
    io.s_valid = 1'b0;

    run_frame("nominal",   512, 512,  0, 1'b1, 1'b0, 1'b0);
    run_frame("backpress", 512, 512, 50, 1'b0, 1'b0, 1'b0);
    run_frame("short100",  100, 100, 20, 1'b0, 1'b0, 1'b0);
    run_frame("long520",   520, 520, 30, 1'b0, 1'b0, 1'b0);
    run_frame("short511",  511, 511,  0, 1'b0, 1'b0, 1'b0);
    run_frame("short1",      1,   1,  0, 1'b0, 1'b0, 1'b0);
    run_frame("long513",   513, 513,  0, 1'b0, 1'b0, 1'b0);
    run_frame("busystart", 512, 512, 10, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a frame, then release together with start.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    io.s_valid = 1'b1;
    io.s_last  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      io.s_real = DW'($urandom);
      io.s_imag = DW'($urandom);
      @(posedge clk); #1;
      if (io.index >= IW'(200)) break;
    end
    chk("abort_reach", 128'(io.index >= IW'(200)), 128'(1));
    #2 rst = 1'b0;
    #1 chk_rst("abort");
    io.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    run_frame("after_rst", 512, 512, 0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
